// File: rtl/addsub_seq_ctrl.sv
// Byte-serial add/subtract sequencer: steps one 8-bit slice with a chained carry,
// LSB first, and returns the W-bit result with carry/borrow and signed-overflow flags.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one byte per cycle, idx = byte being computed
// DONE  | one-cycle done pulse, result/flags valid, start accepted here too
module addsub_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, result_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q, cout_q, ovf_q;
  logic            accept, last;
  logic [7:0]      a_byte, b_byte, s;
  logic            c8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    a_byte  = a_q[{idx_q, 3'b000} +: 8];
    b_byte  = b_q[{idx_q, 3'b000} +: 8];
    {c8, s} = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};
    last    = (idx_q == IW'(NBYTES - 1));
    case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (last) state_d = DONE;
      DONE: begin
        accept  = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtract is a + ~b + 1: the +1 rides in as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      result_q[{idx_q, 3'b000} +: 8] <= s;
      carry_q <= c8;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        cout_q <= c8;
        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (s[7] != a_q[W-1]);
      end
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl (NBYTES=4); expected values hand-computed.
module tb_addsub_seq_ctrl;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  addsub_seq_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Issue one op from a negedge; return at the negedge where done is seen.
  // lat = cycles from start edge to done (-1 on timeout), bcnt = cycles with busy.
  task automatic issue_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                          output int lat, output int bcnt);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = -1;
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (busy) bcnt++;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, cout, ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got busy/done/cout/ovf=%b want 0000", {busy, done, cout, ovf});
    end
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result got %h want 00000000", result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset got busy/done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_add();
    int lat, bcnt;
    issue_op(32'h000000FF, 32'h00000001, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
    checks++;
    if (bcnt !== 4) begin errors++; $display("FAIL add_busy_cycles got %0d want 4", bcnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_done got %b want 0", busy); end
    checks++;
    if ({result, cout, ovf} !== {32'h00000100, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_ff_1 got %h c%b o%b want 00000100 c0 o0", result, cout, ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b want 0", done); end

    issue_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 4 || {result, cout, ovf} !== {32'h80000000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_ovf got lat %0d %h c%b o%b want 4 80000000 c0 o1", lat, result, cout, ovf);
    end
    @(negedge clk);

    issue_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 4 || {result, cout, ovf} !== {32'hFFFFFFFE, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_carry got lat %0d %h c%b o%b want 4 FFFFFFFE c1 o0", lat, result, cout, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat, bcnt;
    issue_op(32'h00000005, 32'h00000007, 1'b1, lat, bcnt);
    checks++;
    if (lat !== 4 || {result, cout, ovf} !== {32'hFFFFFFFE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_borrow got lat %0d %h c%b o%b want 4 FFFFFFFE c0 o0", lat, result, cout, ovf);
    end
    @(negedge clk);

    issue_op(32'h00000007, 32'h00000005, 1'b1, lat, bcnt);
    checks++;
    if (lat !== 4 || {result, cout, ovf} !== {32'h00000002, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_noborrow got lat %0d %h c%b o%b want 4 00000002 c1 o0", lat, result, cout, ovf);
    end
    @(negedge clk);

    issue_op(32'h80000000, 32'h00000001, 1'b1, lat, bcnt);
    checks++;
    if (lat !== 4 || {result, cout, ovf} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_ovf got lat %0d %h c%b o%b want 4 7FFFFFFF c1 o1", lat, result, cout, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat;
    lat = -1;
    a = 32'h12345678; b = 32'h11111111; sub = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01234567; sub = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 2) start = 1'b0;
      if (k == 3) begin a = 32'hFFFFFFFF; b = 32'h0F0F0F0F; end
      if (done) begin lat = k; break; end
    end
    checks++;
    if (lat !== 4 || {result, cout, ovf} !== {32'h23456789, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ignore_midrun got lat %0d %h c%b o%b want 4 23456789 c0 o0", lat, result, cout, ovf);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL no_queued_op got busy/done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = -1; t2 = -1;
    a = 32'h00000001; b = 32'h00000002; sub = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 32'h00000010; b = 32'h00000001; sub = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 5) start = 1'b0;
      if (done) begin
        if (t1 < 0) begin
          t1 = k;
          checks++;
          if ({result, cout, ovf} !== {32'h00000003, 1'b0, 1'b0}) begin
            errors++; $display("FAIL b2b_first got %h c%b o%b want 00000003 c0 o0", result, cout, ovf);
          end
        end else begin
          t2 = k;
          checks++;
          if ({result, cout, ovf} !== {32'h0000000F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_second got %h c%b o%b want 0000000F c1 o0", result, cout, ovf);
          end
          break;
        end
      end
    end
    checks++;
    if (t1 !== 4 || t2 !== 9) begin
      errors++; $display("FAIL b2b_timing got done at %0d,%0d want 4,9", t1, t2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int lat, bcnt, seen;
    a = 32'h01010101; b = 32'h01010101; sub = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, cout, ovf} !== 4'b0000 || result !== 32'h0) begin
      errors++; $display("FAIL midrun_reset got busy%b done%b %h c%b o%b want all 0", busy, done, result, cout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL no_done_after_abort got %0d pulses want 0", seen); end
    issue_op(32'h00010000, 32'h00010000, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 4 || {result, cout, ovf} !== {32'h00020000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL post_reset_add got lat %0d %h c%b o%b want 4 00020000 c0 o0", lat, result, cout, ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
